// File: rtl/mem_dump_engine.sv
// mem_dump_engine
//   Streams a contiguous range of BRAM words out over a valid/ready interface.
//   A dump is requested with start_i; base_addr_i and word_count_i are sampled on
//   the accepted start. Reads are issued on a 1-cycle-latency BRAM port and the
//   returned words pass through a 2-entry FIFO so back-pressure on m_ready_i never
//   loses data, while an unstalled sink still receives one beat per cycle.
//
// Ports
//   clk, reset          : clock (rising edge) and asynchronous active-low reset
//   start_i, abort_i    : begin a dump (IDLE only) / cancel an active dump
//   base_addr_i         : first word address
//   word_count_i        : number of words (0 gives an immediate done_o)
//   busy_o, done_o      : dump in progress / one-cycle completion pulse
//   mem_*               : BRAM port-B master (read only; we/rst tied low)
//   m_data_o, m_addr_o  : stream beat payload and its word address
//   m_valid_o, m_ready_i: stream handshake
//   m_last_o            : set on the final beat of the dump
module mem_dump_engine #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic                  mem_rst_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;    // next address to read
  logic [ADDR_WIDTH:0]   remain_q;     // reads still to issue
  logic                  done_q;

  // Read in flight: BRAM sampled the address last edge, data arrives this cycle.
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  pend_last_q;

  // 2-entry FIFO holding data, its word address and the last-beat flag.
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic       abort_act;
  logic       fifo_push;
  logic       fifo_pop;
  logic [2:0] fill;
  logic       can_issue;
  logic       issue;
  logic       last_issue;

  always_comb begin
    abort_act  = abort_i && (state_q != StIdle);
    fifo_pop   = (fifo_cnt_q != 2'd0) && m_ready_i && !abort_act;
    fifo_push  = rd_pend_q && !abort_act;
    // Occupancy plus the read whose data lands at the next edge.
    fill       = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};
    // A new read lands two edges from now; only allow it if a slot is
    // guaranteed, counting a pop happening this cycle as a freed slot.
    can_issue  = (fill < 3'd2) || ((fill == 3'd2) && fifo_pop);
    issue      = (state_q == StRun) && can_issue && !abort_act;
    last_issue = (remain_q == (ADDR_WIDTH + 1)'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (abort_act) begin
        // Abort wins over start and any beat transfer; in-flight data is dropped.
        state_q    <= StIdle;
        rd_pend_q  <= 1'b0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (word_count_i == '0) begin
                done_q <= 1'b1;
              end else begin
                rd_addr_q <= base_addr_i;
                remain_q  <= word_count_i;
                state_q   <= StRun;
              end
            end
          end
          StRun: begin
            if (issue) begin
              rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
              remain_q  <= remain_q - (ADDR_WIDTH + 1)'(1);
              if (last_issue) begin
                state_q <= StDrain;
              end
            end
          end
          StDrain: begin
            if (fifo_pop && fifo_last_q[rd_ptr_q]) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase

        rd_pend_q <= issue;
        if (issue) begin
          pend_addr_q <= rd_addr_q;
          pend_last_q <= last_issue;
        end

        if (fifo_push) begin
          fifo_data_q[wr_ptr_q] <= mem_data_i;
          fifo_addr_q[wr_ptr_q] <= pend_addr_q;
          fifo_last_q[wr_ptr_q] <= pend_last_q;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (fifo_pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        case ({fifo_push, fifo_pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign mem_en_o   = issue;
  assign mem_addr_o = rd_addr_q;
  assign mem_we_o   = 4'b0000;
  assign mem_rst_o  = 1'b0;
  assign m_valid_o  = (fifo_cnt_q != 2'd0);
  assign m_data_o   = fifo_data_q[rd_ptr_q];
  assign m_addr_o   = fifo_addr_q[rd_ptr_q];
  assign m_last_o   = m_valid_o && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_dump_engine.sv
// Testbench for mem_dump_engine: table of dump scenarios, hand-written reset and
// abort sequences, then randomized dumps, all checked against a queue of expected
// beats built from the dump rules (address = base + i mod 2^15, data = memory).
module tb_mem_dump_engine;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   word_count_i = '0;
  logic          busy_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic          mem_rst_o;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic          m_last_o;

  mem_dump_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .word_count_i(word_count_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_addr_o  (mem_addr_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_rst_o   (mem_rst_o),
    .mem_data_i  (mem_data_i),
    .m_data_o    (m_data_o),
    .m_addr_o    (m_addr_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_en_o) mem_data_i <= mem[mem_addr_o];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   count;
    int            ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int            abort_after;  // -1: no abort
    int            restart_at;   // -1: no second start while busy
    int            exp_beats;
    int            exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] exp_base;
  int            exp_count;
  int            cyc, issued, beats, done_cnt;
  int            first_valid_cyc, last_xfer_cyc, done_cyc;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic start_mon(input logic [AW-1:0] base, input int count);
    beat_t b;
    logic [AW-1:0] a;
    exp_q.delete();
    got_data.delete();
    for (int i = 0; i < count; i++) begin
      a      = base + AW'(i);
      b.addr = a;
      b.data = mem[a];
      b.last = (i == count - 1);
      exp_q.push_back(b);
    end
    exp_base = base; exp_count = count;
    cyc = 0; issued = 0; beats = 0; done_cnt = 0;
    first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  // Called at the falling edge: inputs and outputs are stable for this cycle.
  task automatic monitor();
    bit xfer;
    int oi;
    beat_t b;
    logic [AW-1:0] ea;
    xfer = m_valid_o && m_ready_i && !(abort_i && busy_o);
    if (mem_en_o) begin
      oi = issued - beats;
      ea = exp_base + AW'(issued);
      check("flow_rule", 64'((oi < 2) || ((oi == 2) && xfer)), 64'd1);
      check("rd_addr", 64'(mem_addr_o), 64'(ea));
      check("rd_count", 64'(issued < exp_count), 64'd1);
      issued++;
    end
    if (prev_stall)
      check("stall_hold", {m_valid_o, m_last_o, m_addr_o, m_data_o},
            {1'b1, prev_last, prev_addr, prev_data});
    if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat got addr %0h expected no beat", m_addr_o);
      end else begin
        b = exp_q.pop_front();
        check("beat_addr", 64'(m_addr_o), 64'(b.addr));
        check("beat_data", 64'(m_data_o), 64'(b.data));
        check("beat_last", 64'(m_last_o), 64'(b.last));
      end
      got_data.push_back(m_data_o);
      beats++;
      last_xfer_cyc = cyc;
    end
    prev_stall = m_valid_o && !m_ready_i && !(abort_i && busy_o);
    prev_data = m_data_o; prev_addr = m_addr_o; prev_last = m_last_o;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int  n, budget;
    bit  finished, aborted;
    start_mon(v.base, int'(v.count));
    base_addr_i  = v.base;
    word_count_i = v.count;
    start_i      = 1'b1;
    m_ready_i    = 1'b1;
    cycle();
    start_i  = 1'b0;
    finished = 1'b0;
    aborted  = 1'b0;
    budget   = 6 * int'(v.count) + 40;
    n        = 1;
    while (n < budget) begin
      m_ready_i = ready_for(v.ready_mode, n);
      abort_i   = 1'b0;
      start_i   = 1'b0;
      if (v.abort_after >= 0 && beats == v.abort_after && !aborted) begin
        abort_i = 1'b1;
        aborted = 1'b1;
      end
      if (n == v.restart_at) begin
        start_i      = 1'b1;
        base_addr_i  = v.base ^ 15'h1234;
        word_count_i = 16'd3;
      end
      cycle();
      n++;
      if (n == 2 && v.count != 0) check("busy_run", 64'(busy_o), 64'd1);
      if (aborted) begin
        abort_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_valid", 64'(m_valid_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        monitor();
        @(posedge clk);
        #1;
        finished = 1'b1;
        break;
      end
      if (done_cnt > 0) begin
        finished = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) cycle();
    if (!finished) begin
      checks++; errors++;
      $display("FAIL timeout got %0d beats expected %0d", beats, v.exp_beats);
    end
    check("beats", 64'(beats), 64'(v.exp_beats));
    check("done_pulses", 64'(done_cnt), 64'(v.exp_done));
    check("busy_idle", 64'(busy_o), 64'd0);
    if (!aborted) check("all_delivered", 64'(exp_q.size()), 64'd0);
    if (v.count == 0) check("zero_no_valid", 64'(first_valid_cyc), 64'(-1));
    if (v.exp_done != 0)
      check("done_timing", 64'(done_cyc),
            64'((v.count == 0) ? 1 : last_xfer_cyc + 1));
    if (v.ready_mode == 0 && v.count != 0 && !aborted) begin
      check("first_beat_lat", 64'(first_valid_cyc), 64'd3);
      check("back_to_back", 64'(last_xfer_cyc), 64'(3 + int'(v.count) - 1));
    end
  endtask

  task automatic reset_mid_dump();
    start_mon(15'h1000, 50);
    base_addr_i  = 15'h1000;
    word_count_i = 16'd50;
    start_i      = 1'b1;
    m_ready_i    = 1'b1;
    cycle();
    start_i = 1'b0;
    repeat (7) cycle();
    check("pre_reset_valid", 64'(m_valid_o), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_ctrl", 64'({busy_o, done_o, m_valid_o, m_last_o, mem_en_o, mem_we_o, mem_rst_o}),
          64'd0);
    check("rst_addr", 64'({mem_addr_o, m_addr_o}), 64'd0);
    check("rst_data", 64'(m_data_o), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    start_mon(15'h0, 0);
    repeat (4) cycle();
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_no_valid", 64'(first_valid_cyc), 64'(-1));
    check("rst_idle", 64'(busy_o), 64'd0);
  endtask

  vec_t vecs[8];
  logic [DW-1:0] req28 [4];

  initial begin
    //          base      count  mode abort restart beats done
    vecs[0] = '{15'h0010, 16'd4,   0, -1, -1,   4, 1};
    vecs[1] = '{15'h7FFE, 16'd4,   0, -1, -1,   4, 1};
    vecs[2] = '{15'h0100, 16'd8,   1, -1, -1,   8, 1};
    vecs[3] = '{15'h0040, 16'd0,   0, -1, -1,   0, 1};
    vecs[4] = '{15'h0200, 16'd100, 0, 10, -1,  10, 0};
    vecs[5] = '{15'h0300, 16'd2,   0, -1, -1,   2, 1};
    vecs[6] = '{15'h0400, 16'd6,   1, -1,  4,   6, 1};
    vecs[7] = '{15'h7FFF, 16'd1,   2, -1, -1,   1, 1};
    req28[0] = 32'h30; req28[1] = 32'h33; req28[2] = 32'h36; req28[3] = 32'h39;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);

    repeat (2) @(posedge clk);
    #1;
    check("init_ctrl", 64'({busy_o, done_o, m_valid_o, m_last_o, mem_en_o}), 64'd0);
    check("init_addr", 64'({mem_addr_o, m_addr_o}), 64'd0);
    check("init_data", 64'(m_data_o), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        check("req28_n", 64'(got_data.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_data.size(); k++)
          check("req28_data", 64'(got_data[k]), 64'(req28[k]));
      end
    end

    reset_mid_dump();
    run_vec(vecs[5]);

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int r = 0; r < 20; r++) begin
      vec_t v;
      v.base        = AW'($urandom);
      v.count       = (AW + 1)'($urandom_range(1, 40));
      v.ready_mode  = (r % 4 == 0) ? 0 : 2;
      v.abort_after = (r % 5 == 4) ? int'($urandom_range(0, int'(v.count) - 1)) : -1;
      v.restart_at  = (r % 3 == 1) ? 2 : -1;
      v.exp_beats   = (v.abort_after >= 0) ? v.abort_after : int'(v.count);
      v.exp_done    = (v.abort_after >= 0) ? 0 : 1;
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
